hfrv_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single synchronous memory port of the hfrv core subsystem between N_REQ requesters: CPU fetch, CPU load/store, and the bench loader/debug port. It sits between the requesters and the memory in `dut_top`. Grants at most one access per cycle and supports lock-held bursts. It keeps up to RD_LAT reads in flight and routes each read response back to the requester that issued it.

---
 rtl/hfrv_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_hfrv_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between N_REQ requesters,
// with lock-held bursts and per-requester routing of pipelined read responses.
module hfrv_mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_lock,
    input  logic [N_REQ*ADDR_W-1:0]       req_addr,
    input  logic [N_REQ*DATA_W-1:0]       req_wdata,
    input  logic [N_REQ*(DATA_W/8)-1:0]   req_be,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_be,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [31:0]                   stall_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic            locked;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            active;
    logic            is_read;
    logic [BE_W-1:0] be_sel;
    logic [N_REQ-1:0] grant;
    logic [31:0]     stall_q;
    int              sidx;

    logic            pipe_vld [RD_LAT];
    logic [ID_W-1:0] pipe_id  [RD_LAT];

    // While locked only the owner may win, even if it is idle this cycle.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        sidx     = 0;
        idx      = '0;
        if (locked) begin
            found    = req_valid[owner];
            grant_id = owner;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                sidx = int'(ptr) + k;
                if (sidx >= N_REQ) sidx = sidx - N_REQ;
                idx = ID_W'(sidx);
                if (!found && req_valid[idx]) begin
                    found    = 1'b1;
                    grant_id = idx;
                end
            end
        end
    end

    assign active   = rst_n && found;
    assign be_sel   = req_be[int'(grant_id)*BE_W +: BE_W];
    assign is_read  = (be_sel == '0);
    assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        grant = '0;
        if (active) grant[grant_id] = 1'b1;
    end

    assign req_ready = grant;
    assign mem_en    = active;
    assign mem_addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    assign mem_wdata = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
    assign mem_be    = active ? be_sel : '0;

    // ptr only advances on the access that ends (or never starts) a lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            owner  <= '0;
            locked <= 1'b0;
        end else if (active) begin
            if (locked) begin
                if (!req_lock[grant_id]) begin
                    locked <= 1'b0;
                    ptr    <= next_ptr;
                end
            end else if (req_lock[grant_id]) begin
                locked <= 1'b1;
                owner  <= grant_id;
            end else begin
                ptr <= next_ptr;
            end
        end else if (locked && !req_valid[owner] && !req_lock[owner]) begin
            locked <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_id[s]  <= '0;
            end
        end else begin
            pipe_vld[0] <= active && is_read;
            pipe_id[0]  <= grant_id;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (pipe_vld[RD_LAT-1]) rsp_valid[pipe_id[RD_LAT-1]] = 1'b1;
    end

    assign rsp_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (((req_valid & ~grant) != '0) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Scoreboard bench for hfrv_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share
// the same directed stimulus; each has its own memory model and response monitor.
module tb_hfrv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_lock;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;

    logic [1:0]  ready1, rsp_valid1, ready3, rsp_valid3;
    logic [31:0] rsp_rdata1, mem_addr1, mem_wdata1, mem_rdata1, stall1;
    logic [31:0] rsp_rdata3, mem_addr3, mem_wdata3, mem_rdata3, stall3;
    logic [3:0]  mem_be1, mem_be3;
    logic        mem_en1, mem_en3;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [31:0] mp1;
    logic [31:0] mp3 [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hfrv_mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(ready1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .mem_en(mem_en1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_be(mem_be1),
        .mem_rdata(mem_rdata1), .stall_cnt(stall1)
    );

    hfrv_mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(ready3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .mem_en(mem_en3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_be(mem_be3),
        .mem_rdata(mem_rdata3), .stall_cnt(stall3)
    );

    // Memory model: read data is address+1, delivered RD_LAT edges after the access.
    always @(posedge clk) begin
        mp1    <= mem_addr1 + 32'd1;
        mp3[0] <= mem_addr3 + 32'd1;
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end

    assign mem_rdata1 = mp1;
    assign mem_rdata3 = mp3[2];

    always @(negedge clk) begin
        if (rsp_valid1 != 2'b00) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp1_unexpected: got rsp_valid=%b data=%h at cycle %0d, required no response",
                         rsp_valid1, rsp_rdata1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (rsp_valid1 != 2'(1 << e1.id) || rsp_rdata1 != e1.data || cyc != e1.due) begin
                    errors++;
                    $display("[TB] FAIL rsp1: got valid=%b data=%h cycle=%0d, required valid=%b data=%h cycle=%0d",
                             rsp_valid1, rsp_rdata1, cyc, 2'(1 << e1.id), e1.data, e1.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid3 != 2'b00) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp3_unexpected: got rsp_valid=%b data=%h at cycle %0d, required no response",
                         rsp_valid3, rsp_rdata3, cyc);
            end else begin
                e3 = q3.pop_front();
                if (rsp_valid3 != 2'(1 << e3.id) || rsp_rdata3 != e3.data || cyc != e3.due) begin
                    errors++;
                    $display("[TB] FAIL rsp3: got valid=%b data=%h cycle=%0d, required valid=%b data=%h cycle=%0d",
                             rsp_valid3, rsp_rdata3, cyc, 2'(1 << e3.id), e3.data, e3.due);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] lock,
                                 input logic [31:0] a0, input logic [3:0] be0,
                                 input logic [31:0] a1, input logic [3:0] be1);
        req_valid = valid;
        req_lock  = lock;
        req_addr  = {a1, a0};
        req_wdata = {~a1, ~a0};
        req_be    = {be1, be0};
    endtask

    // Called in the cycle the read is accepted; response due RD_LAT cycles later.
    task automatic expectRead(input int id, input logic [31:0] addr);
        q1.push_back('{id: id, data: addr + 32'd1, due: cyc + 1});
        q3.push_back('{id: id, data: addr + 32'd1, due: cyc + 3});
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_ready,
                               input logic [3:0] exp_be, input logic [31:0] exp_addr);
        @(negedge clk);
        checks++;
        if ({mem_en1, ready1, mem_be1} !== {|exp_ready, exp_ready, exp_be}) begin
            errors++;
            $display("[TB] FAIL %s_lat1: got en=%b ready=%b be=%h, required en=%b ready=%b be=%h",
                     name, mem_en1, ready1, mem_be1, |exp_ready, exp_ready, exp_be);
        end
        checks++;
        if ({mem_en3, ready3, mem_be3} !== {|exp_ready, exp_ready, exp_be}) begin
            errors++;
            $display("[TB] FAIL %s_lat3: got en=%b ready=%b be=%h, required en=%b ready=%b be=%h",
                     name, mem_en3, ready3, mem_be3, |exp_ready, exp_ready, exp_be);
        end
        if (exp_ready != 2'b00) begin
            checks++;
            if (mem_addr1 !== exp_addr || mem_addr3 !== exp_addr) begin
                errors++;
                $display("[TB] FAIL %s_addr: got %h/%h, required %h", name, mem_addr1, mem_addr3, exp_addr);
            end
        end
    endtask

    task automatic checkStall(input string name, input logic [31:0] expv);
        checks++;
        if (stall1 !== expv || stall3 !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got stall_cnt=%h/%h, required %h", name, stall1, stall3, expv);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
        #2 rst_n = 1'b0;
        nextCycle();

        // Reset holds everything off even with both requesters valid.
        applyStimulus(2'b11, 2'b00, 32'h100, 4'h0, 32'h200, 4'h0);
        checkOutput("rst_hold", 2'b00, 4'h0, 32'h0);
        checkStall("rst_stall", 32'd0);
        nextCycle();
        rst_n = 1'b1;

        // Round robin between two readers.
        expectRead(0, 32'h100);
        checkOutput("rr_g0", 2'b01, 4'h0, 32'h100);
        nextCycle();
        expectRead(1, 32'h200);
        checkOutput("rr_g1", 2'b10, 4'h0, 32'h200);
        nextCycle();
        expectRead(0, 32'h100);
        checkOutput("rr_g2", 2'b01, 4'h0, 32'h100);
        nextCycle();
        expectRead(1, 32'h200);
        checkOutput("rr_g3", 2'b10, 4'h0, 32'h200);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
        checkOutput("rr_idle", 2'b00, 4'h0, 32'h0);
        checkStall("rr_stall", 32'd4);
        nextCycle();

        // Single read from 0 moves the pointer to 1 before the burst.
        applyStimulus(2'b01, 2'b00, 32'h300, 4'h0, 32'h0, 4'h0);
        expectRead(0, 32'h300);
        checkOutput("pre_lock", 2'b01, 4'h0, 32'h300);
        nextCycle();

        // Locked write burst from requester 1 while requester 0 keeps asking.
        applyStimulus(2'b11, 2'b10, 32'h500, 4'h0, 32'h40, 4'hF);
        checkOutput("lock_w0", 2'b10, 4'hF, 32'h40);
        nextCycle();
        applyStimulus(2'b11, 2'b10, 32'h500, 4'h0, 32'h44, 4'hF);
        checkOutput("lock_w1", 2'b10, 4'hF, 32'h44);
        nextCycle();
        applyStimulus(2'b01, 2'b10, 32'h500, 4'h0, 32'h44, 4'hF);
        checkOutput("lock_idle", 2'b00, 4'h0, 32'h0);
        nextCycle();
        applyStimulus(2'b11, 2'b10, 32'h500, 4'h0, 32'h48, 4'hF);
        checkOutput("lock_w2", 2'b10, 4'hF, 32'h48);
        nextCycle();
        applyStimulus(2'b11, 2'b00, 32'h500, 4'h0, 32'h4C, 4'hF);
        checkOutput("lock_last", 2'b10, 4'hF, 32'h4C);
        nextCycle();
        applyStimulus(2'b11, 2'b00, 32'h500, 4'h0, 32'h50, 4'hF);
        expectRead(0, 32'h500);
        checkOutput("post_lock", 2'b01, 4'h0, 32'h500);
        nextCycle();

        // Back-to-back reads 0,1,0.
        applyStimulus(2'b01, 2'b00, 32'h600, 4'h0, 32'h0, 4'h0);
        expectRead(0, 32'h600);
        checkOutput("pipe_a", 2'b01, 4'h0, 32'h600);
        nextCycle();
        applyStimulus(2'b10, 2'b00, 32'h0, 4'h0, 32'h700, 4'h0);
        expectRead(1, 32'h700);
        checkOutput("pipe_b", 2'b10, 4'h0, 32'h700);
        nextCycle();
        applyStimulus(2'b01, 2'b00, 32'h604, 4'h0, 32'h0, 4'h0);
        expectRead(0, 32'h604);
        checkOutput("pipe_c", 2'b01, 4'h0, 32'h604);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
        repeat (5) nextCycle();

        // Reset one cycle after a read accept discards it.
        applyStimulus(2'b10, 2'b00, 32'h0, 4'h0, 32'h800, 4'h0);
        checkOutput("rm_accept", 2'b10, 4'h0, 32'h800);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(2'b11, 2'b00, 32'h900, 4'h0, 32'hA00, 4'h0);
        checkOutput("rm_rst", 2'b00, 4'h0, 32'h0);
        repeat (3) nextCycle();
        rst_n = 1'b1;
        expectRead(0, 32'h900);
        checkOutput("rm_prio", 2'b01, 4'h0, 32'h900);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
        repeat (5) nextCycle();

        // Saturation: preload near the top with a stall every cycle.
        applyStimulus(2'b11, 2'b00, 32'hB00, 4'hF, 32'hC00, 4'hF);
        force u_dut1.stall_q = 32'hFFFF_FFFE;
        force u_dut3.stall_q = 32'hFFFF_FFFE;
        nextCycle();
        release u_dut1.stall_q;
        release u_dut3.stall_q;
        repeat (3) nextCycle();
        @(negedge clk);
        checkStall("sat_hold", 32'hFFFF_FFFF);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
        checkOutput("sat_idle", 2'b00, 4'h0, 32'h0);
        checkStall("sat_idle_stall", 32'hFFFF_FFFF);

        repeat (5) nextCycle();
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_lat1: got %0d responses outstanding, required 0", q1.size());
        end
        checks++;
        if (q3.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_lat3: got %0d responses outstanding, required 0", q3.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
